bluejay_line_streamer: RTL and testbench

Parametrised successor to the Bluejay SLM data sequencer. It pulls complete display lines from the upstream sc32 FIFO and drives them onto the Bluejay data bus with per-line sync and per-word valid. It adds configurable bus width, line length, frame height and inter-line gap, plus frame tracking gated by buffer_switch_done. It sits between the line FIFO and the Bluejay output pins.

---
 rtl/bluejay_pkg.sv | 23 ++
 rtl/bluejay_line_timer.sv | 66 ++++++
 rtl/bluejay_line_streamer.sv | 196 +++++++++++++++++++
 tb/tb_bluejay_line_streamer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bluejay_pkg.sv
// Shared types and geometry defaults for the Bluejay line streamer and its FIFO writer.
package bluejay_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    STREAM,
    DRAIN,
    GAP,
    FRAME_WAIT
  } bluejay_state_t;

  localparam int unsigned BJ_DATA_W          = 32;
  localparam int unsigned BJ_WORDS_PER_LINE  = 40;
  localparam int unsigned BJ_LINES_PER_FRAME = 1280;
  localparam int unsigned BJ_GAP_CYCLES      = 4;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bluejay_line_timer.sv
// Word, gap and line counters for the Bluejay line streamer, with terminal-count flags.
module bluejay_line_timer
  import bluejay_pkg::*;
#(
  parameter  int unsigned WORDS_PER_LINE  = BJ_WORDS_PER_LINE,
  parameter  int unsigned LINES_PER_FRAME = BJ_LINES_PER_FRAME,
  parameter  int unsigned GAP_CYCLES      = BJ_GAP_CYCLES,
  localparam int unsigned WW              = cnt_w(WORDS_PER_LINE + 1),
  localparam int unsigned LW              = cnt_w(LINES_PER_FRAME),
  localparam int unsigned GW              = cnt_w(GAP_CYCLES + 1)
) (
  input  logic          fpga_clk,
  input  logic          reset,
  input  logic          word_load,
  input  logic          word_inc,
  input  logic          gap_run,
  input  logic          line_step,
  output logic [WW-1:0] word_cnt,
  output logic          word_last,
  output logic          gap_done,
  output logic          line_last,
  output logic [LW-1:0] line_index
);

  localparam logic [WW-1:0] WORD_LAST = WW'(WORDS_PER_LINE - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [LW-1:0] LINE_LAST = LW'(LINES_PER_FRAME - 1);

  logic [WW-1:0] word_cnt_q, word_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [LW-1:0] line_q, line_d;

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (word_load) begin
      word_cnt_d = WW'(1);
    end else if (word_inc) begin
      word_cnt_d = word_cnt_q + WW'(1);
    end
    // The gap counter only runs inside GAP and is cleared everywhere else.
    gap_cnt_d = gap_run ? gap_cnt_q + GW'(1) : '0;
    line_d = line_q;
    if (line_step) begin
      line_d = (line_q == LINE_LAST) ? '0 : line_q + LW'(1);
    end
  end

  always_ff @(posedge fpga_clk) begin
    if (reset) begin
      word_cnt_q <= '0;
      gap_cnt_q  <= '0;
      line_q     <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      line_q     <= line_d;
    end
  end

  assign word_cnt   = word_cnt_q;
  assign word_last  = (word_cnt_q == WORD_LAST);
  assign gap_done   = (GAP_CYCLES == 0) || (gap_cnt_q == GAP_LAST);
  assign line_last  = (line_q == LINE_LAST);
  assign line_index = line_q;

endmodule

// File: rtl/bluejay_line_streamer.sv
// Streams complete lines from the sc32 FIFO onto the Bluejay bus with sync/valid framing.
// Define BLUEJAY_TEST_PATTERN_EN to add the pattern_mode input and the built-in test pattern.
module bluejay_line_streamer
  import bluejay_pkg::*;
#(
  parameter int unsigned DATA_W          = BJ_DATA_W,
  parameter int unsigned WORDS_PER_LINE  = BJ_WORDS_PER_LINE,
  parameter int unsigned LINES_PER_FRAME = BJ_LINES_PER_FRAME,
  parameter int unsigned GAP_CYCLES      = BJ_GAP_CYCLES
) (
  input  logic                              fpga_clk,
  input  logic                              reset,
  input  logic                              buffer_switch_done,
  input  logic [DATA_W-1:0]                 fifo_data_out,
  input  logic                              line_of_data_available,
  input  logic                              sc32_fifo_almost_empty,
`ifdef BLUEJAY_TEST_PATTERN_EN
  input  logic                              pattern_mode,
`endif
  output logic                              get_next_word,
  output logic [DATA_W-1:0]                 bluejay_data_out,
  output logic                              sync,
  output logic                              valid,
  output logic                              frame_start,
  output logic [cnt_w(LINES_PER_FRAME)-1:0] line_index,
  output logic                              underrun
);

  localparam int unsigned   WW       = cnt_w(WORDS_PER_LINE + 1);
  localparam int unsigned   LW       = cnt_w(LINES_PER_FRAME);
  localparam logic [WW-1:0] UR_LIMIT = WW'(WORDS_PER_LINE - 2);

  bluejay_state_t    state_q, state_d;
  logic              pend_q, pend_d;
  logic              sync_q, sync_d;
  logic              frame_start_q, frame_start_d;
  logic              issue_q, issue_d;
  logic              get_next_word_q, get_next_word_d;
  logic              rd_q, rd_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              underrun_q, underrun_d;

  logic              word_load, word_inc, gap_run, line_step;
  logic [WW-1:0]     word_cnt;
  logic              word_last, gap_done, line_last;
  logic [LW-1:0]     line_idx;
  logic              pat_en;
  logic [DATA_W-1:0] src_data;

  bluejay_line_timer #(
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .LINES_PER_FRAME(LINES_PER_FRAME),
    .GAP_CYCLES     (GAP_CYCLES)
  ) u_timer (
    .fpga_clk  (fpga_clk),
    .reset     (reset),
    .word_load (word_load),
    .word_inc  (word_inc),
    .gap_run   (gap_run),
    .line_step (line_step),
    .word_cnt  (word_cnt),
    .word_last (word_last),
    .gap_done  (gap_done),
    .line_last (line_last),
    .line_index(line_idx)
  );

`ifdef BLUEJAY_TEST_PATTERN_EN
  logic [DATA_W-1:0] pat_q, pat_d;
  logic              pat_sel_q, pat_sel_d;
  logic [LW+WW-1:0]  pat_cat;

  // The pattern word is formed in the read cycle so it lines up with FIFO read latency.
  always_comb begin
    pat_cat   = {line_idx, (state_q == SYNC) ? {WW{1'b0}} : word_cnt};
    pat_d     = DATA_W'(pat_cat);
    pat_sel_d = pattern_mode;
  end

  always_ff @(posedge fpga_clk) begin
    if (reset) begin
      pat_q     <= '0;
      pat_sel_q <= 1'b0;
    end else begin
      pat_q     <= pat_d;
      pat_sel_q <= pat_sel_d;
    end
  end

  assign pat_en   = pattern_mode;
  assign src_data = pat_sel_q ? pat_q : fifo_data_out;
`else
  assign pat_en   = 1'b0;
  assign src_data = fifo_data_out;
`endif

  always_comb begin
    state_d    = state_q;
    word_load  = 1'b0;
    word_inc   = 1'b0;
    gap_run    = 1'b0;
    line_step  = 1'b0;
    pend_d     = pend_q | buffer_switch_done;
    underrun_d = underrun_q;

    case (state_q)
      IDLE: begin
        if (pat_en || (line_of_data_available && !sc32_fifo_almost_empty)) begin
          state_d = SYNC;
        end
      end
      SYNC: begin
        word_load = 1'b1;
        state_d   = STREAM;
      end
      STREAM: begin
        word_inc = 1'b1;
        if (!pat_en && sc32_fifo_almost_empty && (word_cnt < UR_LIMIT)) begin
          underrun_d = 1'b1;
        end
        if (word_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Once no read is in flight, the last word sits in the output register.
        if (!rd_q) begin
          if (GAP_CYCLES == 0) begin
            line_step = 1'b1;
            state_d   = line_last ? FRAME_WAIT : IDLE;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        gap_run = !gap_done;
        if (gap_done) begin
          line_step = 1'b1;
          state_d   = line_last ? FRAME_WAIT : IDLE;
        end
      end
      FRAME_WAIT: begin
        if (pend_d) begin
          pend_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    sync_d          = (state_d == SYNC);
    frame_start_d   = sync_d && (line_idx == '0);
    issue_d         = (state_d == SYNC) || (state_d == STREAM);
    get_next_word_d = issue_d && !pat_en;
    rd_d            = issue_q;
    valid_d         = rd_q;
    data_d          = rd_q ? src_data : data_q;
  end

  always_ff @(posedge fpga_clk) begin
    if (reset) begin
      state_q         <= IDLE;
      pend_q          <= 1'b1;
      sync_q          <= 1'b0;
      frame_start_q   <= 1'b0;
      issue_q         <= 1'b0;
      get_next_word_q <= 1'b0;
      rd_q            <= 1'b0;
      valid_q         <= 1'b0;
      data_q          <= '0;
      underrun_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      pend_q          <= pend_d;
      sync_q          <= sync_d;
      frame_start_q   <= frame_start_d;
      issue_q         <= issue_d;
      get_next_word_q <= get_next_word_d;
      rd_q            <= rd_d;
      valid_q         <= valid_d;
      data_q          <= data_d;
      underrun_q      <= underrun_d;
    end
  end

  assign get_next_word    = get_next_word_q;
  assign bluejay_data_out = data_q;
  assign sync             = sync_q;
  assign valid            = valid_q;
  assign frame_start      = frame_start_q;
  assign line_index       = line_idx;
  assign underrun         = underrun_q;

endmodule

// File: tb/tb_bluejay_line_streamer.sv
// Directed self-checking bench: a 4-word/3-line/gap-2 instance and an 8-word/2-line/gap-0 instance.
module tb_bluejay_line_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, bsd;
  logic        la4, ae4, la8, ae8;
  logic [31:0] fifo4, fifo8;
  logic        gnw4, sync4, valid4, fs4, ur4;
  logic        gnw8, sync8, valid8, fs8, ur8;
  logic [31:0] data4, data8;
  logic [1:0]  li4;
  logic [0:0]  li8;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          n;
  logic [31:0] ptr4, ptr8;

  bluejay_line_streamer #(
    .DATA_W(32), .WORDS_PER_LINE(4), .LINES_PER_FRAME(3), .GAP_CYCLES(2)
  ) u_dut4 (
    .fpga_clk(clk), .reset(reset), .buffer_switch_done(bsd),
    .fifo_data_out(fifo4), .line_of_data_available(la4), .sc32_fifo_almost_empty(ae4),
`ifdef BLUEJAY_TEST_PATTERN_EN
    .pattern_mode(1'b0),
`endif
    .get_next_word(gnw4), .bluejay_data_out(data4), .sync(sync4), .valid(valid4),
    .frame_start(fs4), .line_index(li4), .underrun(ur4)
  );

  bluejay_line_streamer #(
    .DATA_W(32), .WORDS_PER_LINE(8), .LINES_PER_FRAME(2), .GAP_CYCLES(0)
  ) u_dut8 (
    .fpga_clk(clk), .reset(reset), .buffer_switch_done(bsd),
    .fifo_data_out(fifo8), .line_of_data_available(la8), .sc32_fifo_almost_empty(ae8),
`ifdef BLUEJAY_TEST_PATTERN_EN
    .pattern_mode(1'b0),
`endif
    .get_next_word(gnw8), .bluejay_data_out(data8), .sync(sync8), .valid(valid8),
    .frame_start(fs8), .line_index(li8), .underrun(ur8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock; FIFO models return the next ramp word one cycle after a read.
  task automatic tick();
    logic g4, g8;
    g4 = gnw4;
    g8 = gnw8;
    @(posedge clk);
    #1;
    bsd = 1'b0;
    cyc++;
    if (g4) begin
      fifo4 = ptr4;
      ptr4  = ptr4 + 1;
    end
    if (g8) begin
      fifo8 = ptr8;
      ptr8  = ptr8 + 1;
    end
  endtask

  task automatic wait_sync(input bit use8, input int budget, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (((use8 ? sync8 : sync4) !== 1'b1) && (cnt < budget));
    chk("sync_seen", use8 ? sync8 : sync4, 1);
  endtask

  // Called on the sync cycle of a 4-word line; returns on its last valid word.
  task automatic check_line(input logic [31:0] base, input int line);
    $display("line: dut4 index=%0d first_word=0x%0h cycle=%0d", line, base, cyc);
    chk("sync", sync4, 1);
    chk("frame_start", fs4, (line == 0));
    chk("line_index", li4, line);
    chk("gnw_at_sync", gnw4, 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("sync_low", sync4, 0);
      chk("gnw", gnw4, (k <= 3));
      chk("valid", valid4, (k >= 2));
      if (k >= 2) chk("data", data4, base + 32'(k - 2));
    end
  endtask

  task automatic finish_line(input logic [31:0] last_word, input int exp_n);
    int m;
    tick();
    chk("valid_drop", valid4, 0);
    chk("data_hold", data4, last_word);
    wait_sync(1'b0, 20, m);
    chk("sync_spacing", m, exp_n);
  endtask

  task automatic run_line8(input logic [31:0] base, input int ae_k0, input int ae_k1);
    $display("line: dut8 index=%0d first_word=0x%0h cycle=%0d", li8, base, cyc);
    for (int k = 1; k <= 9; k++) begin
      tick();
      ae8 = (k == ae_k0) || (k == ae_k1);
      chk("gnw8", gnw8, (k <= 7));
      chk("valid8", valid8, (k >= 2));
      if (k >= 2) chk("data8", data8, base + 32'(k - 2));
    end
    ae8 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; bsd = 1'b0;
    la4 = 1'b0; ae4 = 1'b0; la8 = 1'b0; ae8 = 1'b0;
    fifo4 = '0; fifo8 = '0;
    ptr4 = 32'h10; ptr8 = 32'h100;
    repeat (3) tick();
    chk("rst_ctl4", {sync4, valid4, gnw4, fs4, ur4, li4}, 0);
    chk("rst_data4", data4, 0);
    chk("rst_ctl8", {sync8, valid8, gnw8, fs8, ur8, li8}, 0);

    // Frame 0: the reset-time switch credit lets the frame end pass straight through.
    reset = 1'b0; la4 = 1'b1;
    wait_sync(1'b0, 5, n);
    chk("first_sync_delay", n, 1);
    check_line(32'h10, 0); finish_line(32'h13, 3);
    check_line(32'h14, 1); finish_line(32'h17, 3);
    check_line(32'h18, 2); finish_line(32'h1B, 4);

    // Frame 1: no credit, so the end of frame waits for the switch pulse.
    check_line(32'h1C, 0); finish_line(32'h1F, 3);
    check_line(32'h20, 1); finish_line(32'h23, 3);
    check_line(32'h24, 2);
    tick();
    chk("valid_drop", valid4, 0);
    repeat (2) tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("fw_hold_sync", sync4, 0);
      chk("fw_hold_gnw", gnw4, 0);
    end
    bsd = 1'b1;
    wait_sync(1'b0, 10, n);
    chk("switch_to_sync", n, 2);

    // Frame 2: pulse arrives early, during the last line.
    check_line(32'h28, 0); finish_line(32'h2B, 3);
    check_line(32'h2C, 1); finish_line(32'h2F, 3);
    bsd = 1'b1;
    check_line(32'h30, 2); finish_line(32'h33, 4);

    // Line start gating in IDLE.
    check_line(32'h34, 0);
    tick();
    la4 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("no_avail_sync", sync4, 0);
      chk("no_avail_gnw", gnw4, 0);
    end
    la4 = 1'b1; ae4 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("almost_empty_sync", sync4, 0);
      chk("almost_empty_gnw", gnw4, 0);
    end
    ae4 = 1'b0;
    tick();
    chk("idle_release", sync4, 1);
    chk("no_underrun4", ur4, 0);
    check_line(32'h38, 1);

    // Reset on the second valid word of line 2.
    tick();
    wait_sync(1'b0, 10, n);
    chk("sync_spacing", n, 3);
    repeat (3) tick();
    chk("mid_valid", valid4, 1);
    chk("mid_data", data4, 32'h3D);
    reset = 1'b1;
    tick();
    chk("mid_rst_ctl", {sync4, valid4, gnw4, fs4, ur4, li4}, 0);
    chk("mid_rst_data", data4, 0);
    reset = 1'b0;
    ptr4 = 32'h80;
    wait_sync(1'b0, 5, n);
    chk("restart_delay", n, 1);
    check_line(32'h80, 0);
    la4 = 1'b0;

    // Underrun threshold on the 8-word instance.
    la8 = 1'b1;
    wait_sync(1'b1, 5, n);
    chk("sync8_delay", n, 1);
    la8 = 1'b0;
    chk("frame_start8", fs8, 1);
    run_line8(32'h100, 6, 7);
    tick();
    chk("ur_boundary", ur8, 0);
    chk("valid8_drop", valid8, 0);

    la8 = 1'b1;
    wait_sync(1'b1, 5, n);
    la8 = 1'b0;
    chk("line_index8", li8, 1);
    run_line8(32'h108, 1, 1);
    tick();
    chk("ur_set", ur8, 1);
    repeat (3) tick();
    chk("ur_sticky", ur8, 1);
    reset = 1'b1;
    tick();
    chk("ur_reset", ur8, 0);
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
